// File: rtl/wave_gen_multi_if.sv
// Control/sample bundle for wave_gen_multi: the driver owns the controls,
// the generator owns the sample and its two strobes.
interface wave_gen_multi_if #(
    parameter int WIDTH   = 12,
    parameter int STEP_W  = 8,
    parameter int PRESC_W = 16
);
    logic               enable;
    logic [1:0]         mode;
    logic [STEP_W-1:0]  step;
    logic [PRESC_W-1:0] period;
    logic [WIDTH-1:0]   sample;
    logic               sample_valid;
    logic               cycle_start;

    modport master (
        output enable, mode, step, period,
        input  sample, sample_valid, cycle_start
    );

    modport slave (
        input  enable, mode, step, period,
        output sample, sample_valid, cycle_start
    );
endinterface

// File: rtl/wave_gen_multi.sv
// Multi-mode waveform generator: prescaler -> phase accumulator -> shaper.
// Define WAVEGEN_SYNC_UPDATE_EN to latch mode/step only on waveform wraps.
module wave_gen_multi #(
    parameter int WIDTH   = 12,
    parameter int STEP_W  = 8,
    parameter int PRESC_W = 16
) (
    input  logic            qzt_clk,
    input  logic            reset,
    wave_gen_multi_if.slave bus
);
    localparam logic [1:0] MODE_SAW_UP   = 2'b00;
    localparam logic [1:0] MODE_SAW_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;
    localparam logic [1:0] MODE_SQUARE   = 2'b11;

    localparam logic [PRESC_W-1:0] PC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic               sample_valid_q;
    logic               cycle_start_q;

    logic [1:0]         mode_act;
    logic [STEP_W-1:0]  step_act;
    logic [WIDTH-1:0]   step_ext;
    logic [WIDTH:0]     acc_sum;
    logic [PRESC_W-1:0] period_m1;
    logic               tick;
    logic               wrap;

    function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] a,
                                               input logic [1:0]       m);
        logic [WIDTH-1:0] dbl;
        dbl = {a[WIDTH-2:0], 1'b0};
        case (m)
            MODE_SAW_UP:   shape = a;
            MODE_SAW_DOWN: shape = ~a;
            MODE_TRIANGLE: shape = a[WIDTH-1] ? ~dbl : dbl;
            MODE_SQUARE:   shape = {WIDTH{a[WIDTH-1]}};
            default:       shape = a;
        endcase
    endfunction

    // '>=' lets a shortened period take effect without running out the old count.
    assign period_m1 = bus.period - PC_ONE;
    assign tick      = bus.enable && ((bus.period == '0) || (pc_q >= period_m1));

    assign step_ext  = WIDTH'(step_act);
    assign acc_sum   = {1'b0, acc_q} + {1'b0, step_ext};
    assign wrap      = tick && acc_sum[WIDTH];

    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        if (tick) begin
            pc_d     = '0;
            acc_d    = acc_sum[WIDTH-1:0];
            sample_d = shape(acc_sum[WIDTH-1:0], mode_act);
        end else if (bus.enable) begin
            pc_d = pc_q + PC_ONE;
        end
    end

`ifdef WAVEGEN_SYNC_UPDATE_EN
    logic [1:0]        mode_sh_q;
    logic [STEP_W-1:0] step_sh_q;

    // A zero step never wraps, so reload every tick to avoid locking at step 0.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            mode_sh_q <= bus.mode;
            step_sh_q <= bus.step;
        end else if (tick && (wrap || (step_sh_q == '0))) begin
            mode_sh_q <= bus.mode;
            step_sh_q <= bus.step;
        end
    end

    assign mode_act = mode_sh_q;
    assign step_act = step_sh_q;
`else
    assign mode_act = bus.mode;
    assign step_act = bus.step;
`endif

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            pc_q           <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            cycle_start_q  <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= tick;
            cycle_start_q  <= wrap;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.cycle_start  = cycle_start_q;
endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed bench for wave_gen_multi (WIDTH=12, STEP_W=12) with hand-computed
// sample sequences for every mode, prescaler timing, enable and reset.
module tb_wave_gen_multi;
    localparam int WIDTH   = 12;
    localparam int STEP_W  = 12;
    localparam int PRESC_W = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wave_gen_multi_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PRESC_W(PRESC_W)) bus ();

    wave_gen_multi #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PRESC_W(PRESC_W)) dut (
        .qzt_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
    endtask

    initial begin
        int npulse;
        int e1, e2;
        logic [11:0] sq_tab [0:3];
        logic [11:0] tri_tab [0:7];
        sq_tab  = '{12'd0, 12'd4095, 12'd4095, 12'd0};
        tri_tab = '{12'd1024, 12'd2048, 12'd3072, 12'd4095,
                    12'd3071, 12'd2047, 12'd1023, 12'd0};
        checks = 0;
        errors = 0;

        // Reset state
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.mode   = 2'b00;
        bus.step   = 12'd1;
        bus.period = 16'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", bus.sample, 0);
        chk("rst_vld", bus.sample_valid, 0);
        chk("rst_cs", bus.cycle_start, 0);
        reset = 1'b0;

        // Saw up, step 1, period 1: full ramp with wrap on the 4096th tick
        for (int i = 1; i <= 4096; i++) begin
            step_clk();
            chk("saw_up", bus.sample, i % 4096);
            chk("saw_up_vld", bus.sample_valid, 1);
            chk("saw_up_cs", bus.cycle_start, (i == 4096));
        end

        // Period 4, step 16
        bus.step   = 12'd16;
        bus.period = 16'd4;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            chk("p4_vld", bus.sample_valid, (k % 4 == 0));
            chk("p4_sample", bus.sample, 16 * (k / 4));
        end

        // Period 100 shortened to 3 while pc=50
        bus.period = 16'd100;
        do_reset();
        npulse = 0;
        for (int k = 1; k <= 50; k++) begin
            step_clk();
            if (bus.sample_valid) npulse++;
        end
        chk("p100_quiet", npulse, 0);
        bus.period = 16'd3;
        for (int j = 1; j <= 7; j++) begin
            step_clk();
            chk("p3_vld", bus.sample_valid, (j % 3 == 1));
            chk("p3_sample", bus.sample, 16 * ((j + 2) / 3));
        end

        // Saw down, step 256
        bus.mode   = 2'b01;
        bus.step   = 12'd256;
        bus.period = 16'd1;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step_clk();
            chk("saw_dn", bus.sample, 4095 - ((256 * k) % 4096));
            chk("saw_dn_cs", bus.cycle_start, (k == 16));
        end

        // Square, step 1024
        bus.mode = 2'b11;
        bus.step = 12'd1024;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step_clk();
            chk("square", bus.sample, sq_tab[k % 4]);
            chk("square_cs", bus.cycle_start, (k % 4 == 3));
        end

        // Triangle, step 512
        bus.mode = 2'b10;
        bus.step = 12'd512;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step_clk();
            chk("tri", bus.sample, tri_tab[k % 8]);
            chk("tri_cs", bus.cycle_start, (k % 8 == 7));
        end

        // Step 0: frozen accumulator, ticks still strobe
        bus.mode   = 2'b00;
        bus.step   = 12'd0;
        bus.period = 16'd2;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            chk("s0_vld", bus.sample_valid, (k % 2 == 0));
            chk("s0_sample", bus.sample, 0);
            chk("s0_cs", bus.cycle_start, 0);
        end
        bus.step = 12'd4;
`ifdef WAVEGEN_SYNC_UPDATE_EN
        e1 = 0;
        e2 = 4;
`else
        e1 = 4;
        e2 = 8;
`endif
        step_clk();
        chk("s0_resume1", bus.sample, 0);
        step_clk();
        chk("s0_resume2", bus.sample, e1);
        step_clk();
        chk("s0_resume3", bus.sample, e1);
        step_clk();
        chk("s0_resume4", bus.sample, e2);

        // Mid-period switch from saw up to saw down at acc=1000
        bus.step   = 12'd1;
        bus.period = 16'd1;
        do_reset();
        repeat (1000) @(posedge clk);
        #1;
        chk("sw_pre", bus.sample, 1000);
        bus.mode = 2'b01;
`ifdef WAVEGEN_SYNC_UPDATE_EN
        for (int k = 1; k <= 3095; k++) begin
            step_clk();
            chk("sw_hold", bus.sample, 1000 + k);
        end
        step_clk();
        chk("sw_wrap", bus.sample, 0);
        chk("sw_wrap_cs", bus.cycle_start, 1);
        step_clk();
        chk("sw_post", bus.sample, 4094);
`else
        step_clk();
        chk("sw_post", bus.sample, 3094);
        step_clk();
        chk("sw_post2", bus.sample, 3093);
`endif

        // Enable low freezes everything; reset aborts mid-ramp
        bus.mode = 2'b00;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("en_pre", bus.sample, 10);
        bus.enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step_clk();
            chk("en_hold", bus.sample, 10);
            chk("en_vld", bus.sample_valid, 0);
            chk("en_cs", bus.cycle_start, 0);
        end
        bus.enable = 1'b1;
        step_clk();
        chk("en_resume", bus.sample, 11);
        chk("en_resume_vld", bus.sample_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_ramp", bus.sample, 16);
        reset = 1'b1;
        step_clk();
        chk("abort_sample", bus.sample, 0);
        chk("abort_vld", bus.sample_valid, 0);
        chk("abort_cs", bus.cycle_start, 0);
        reset = 1'b0;
        step_clk();
        chk("restart1", bus.sample, 1);
        step_clk();
        chk("restart2", bus.sample, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wave_gen_multi.md
# wave_gen_multi

Parametrised multi-mode waveform generator: the next-generation replacement for the fixed 12-bit sawtooth counter feeding the DAC driver. A programmable prescaler sets the update rate, a phase accumulator with programmable step sets the slope/frequency, and a mode select chooses sawtooth-up, sawtooth-down, triangle or square. The registered sample feeds `Va`/`Vb` of the DAC driver; `sample_valid` and `cycle_start` serve as strobes for downstream logic and scope triggering.

## Interface
- `WIDTH`, 12: sample and accumulator width in bits (DAC resolution); minimum 2.
- `STEP_W`, 8: width of `step`; must be ≤ `WIDTH`.
- `PRESC_W`, 16: width of `period`.

- `qzt_clk`  in  1  system clock (50 MHz board clock); all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `enable`  in  1  high: prescaler runs; low: prescaler, accumulator and `sample` hold.
- `mode`  in  2  00 saw up, 01 saw down, 10 triangle, 11 square.
- `step`  in  STEP_W  accumulator increment per tick, zero-extended.
- `period`  in  PRESC_W  clocks per tick; 0 is treated as 1.
- `sample`  out  WIDTH  registered waveform value.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `cycle_start`  out  1  one-cycle pulse when the accumulator wraps.

## Operation
- Prescaler `pc` (PRESC_W bits): when `enable` is high, tick is asserted if `pc >= period-1`, or if `period == 0`. On tick, `pc` is set to 0; otherwise `pc` increments. The `>=` comparison makes a shortened `period` take effect without a long run-out.
- Accumulator `acc` (WIDTH bits): on tick, `acc <= acc + step`, modulo 2^WIDTH. A carry out of bit WIDTH-1 is a wrap.
- Waveform is a function `f(a)` applied to `acc_next` and registered into `sample`:
  - saw up: `a`.
  - saw down: `~a`.
  - triangle: `a[W-1] ? ~{a[W-2:0],0} : {a[W-2:0],0}`.
  - square: all ones if `a[W-1]`, else 0.
- `step == 0`: `acc` freezes, no wraps occur, and `sample_valid` still pulses each tick.
- `enable` low: no ticks; every register holds its value, and both strobes stay 0.
- `reset` has priority over everything and clears `pc`, `acc`, `sample`, `sample_valid` and `cycle_start` to 0 in the same edge. Asserting it mid-waveform aborts immediately.
- Simultaneous tick and wrap: `sample_valid` and `cycle_start` are both 1 in the same cycle.

## Timing
- Tick decision in cycle N: `acc`, `sample`, `sample_valid` and `cycle_start` all update at the edge ending cycle N. Latency from tick to visible sample is 1 clock.
- With `period = P` (P ≥ 1), `sample_valid` pulses exactly every P clocks. The first pulse after reset release comes P clocks later, at the Pth edge.
- Output frequency = 50 MHz / (P · 2^WIDTH / step) when step divides 2^WIDTH.
- `mode`, `step` and `period` are sampled combinationally at the tick edge; there is no input registering (but see Configuration).
- The strobes are never high for two consecutive cycles unless P = 1.

## Configuration
- `WAVEGEN_SYNC_UPDATE_EN` defined:
  - `mode` and `step` pass through shadow registers. The shadows load at reset and at every wrap tick.
  - If the active step is 0, the shadows load on every tick, so the block cannot deadlock.
  - Result: mode and slope change only on a waveform-period boundary, with no glitch.
- Not defined: `mode` and `step` act on the very next tick, continuing from the current `acc`.
- `period` is always immediate in both builds.

## Test plan
- WIDTH=12, mode=00, step=1, period=1, enable=1 after reset → `sample` = 1, 2, …, 4095, 0 on consecutive clocks. `cycle_start` is high only with the 0 (4096th tick).
- period=4, step=16 → `sample_valid` every 4th clock, `sample` = 16, 32, 48 …. Changing period from 100 to 3 while pc=50 → tick on the next clock, then every 3 clocks.
- mode=01, step=256 → 3839, 3583, …, 255, 4095 (wrap, `cycle_start`=1). Then mode=11, step=1024 → 0, 4095, 4095, 0 ….
- mode=10, step=512 → 1024, 2048, 3072, 4095, 3071, 2047, 1023, 0, repeating.
- Mid-period switch from mode=00 to mode=01 at acc=1000, step=1:
  - without macro, the next sample is ~1001 = 3094;
  - with `WAVEGEN_SYNC_UPDATE_EN`, the saw-up sequence continues to 4095, then 0 with `cycle_start`, then the next sample is ~1 = 4094.
- enable low for 20 clocks → outputs frozen and strobes 0. Then reset asserted mid-ramp → next edge `sample`=0, `sample_valid`=0, `cycle_start`=0, and the ramp restarts from 0.
